block_motion_ctrl: RTL

- Upstream of the block sprite renderer. Produces the sprite's position (x_out, y_out) and the is_fixed_out select.
- Owns the life of one falling block: spawn, per-frame gravity, left/right moves from debounced buttons, floor landing.
- All motion is applied once per video frame, on the new-frame strobe from the video timing chain.

---
 rtl/block_motion_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/block_motion_ctrl.sv
// block_motion_ctrl
//   Controls the life of one falling block for the sprite renderer: spawn,
//   per-frame gravity, left/right moves from debounced buttons, and floor
//   landing. All motion is applied on the one-cycle new-frame strobe.
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous, active-high reset
//   nf_in         one-cycle new-frame strobe
//   spawn_in      level, request a new block (ignored while falling)
//   left_in       debounced left button, level
//   right_in      debounced right button, level
//   x_out         block left edge (11 bits)
//   y_out         block top edge (10 bits)
//   is_fixed_out  1 = sprite drawn at the parked position (IDLE)
//   active_out    1 while the block is falling
//   landed_out    one-cycle pulse when the block reaches the floor
module block_motion_ctrl #(
  parameter int SCREEN_W        = 1280,
  parameter int FLOOR_Y         = 720,
  parameter int BLOCK_W         = 64,
  parameter int BLOCK_H         = 64,
  parameter int START_X         = 608,
  parameter int START_Y         = 0,
  parameter int MOVE_STEP       = 64,
  parameter int FALL_STEP       = 8,
  parameter int FRAMES_PER_FALL = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        nf_in,
  input  logic        spawn_in,
  input  logic        left_in,
  input  logic        right_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        is_fixed_out,
  output logic        active_out,
  output logic        landed_out
);

  localparam int CNT_W = (FRAMES_PER_FALL > 1) ? $clog2(FRAMES_PER_FALL) : 1;

  // Constants sized to the datapath so every compare is width-matched.
  localparam logic [11:0]      MOVE_12   = 12'(MOVE_STEP);
  localparam logic [11:0]      BLKW_12   = 12'(BLOCK_W);
  localparam logic [11:0]      SCRW_12   = 12'(SCREEN_W);
  localparam logic [11:0]      FALL_12   = 12'(FALL_STEP);
  localparam logic [11:0]      LAND_12   = 12'(FLOOR_Y - BLOCK_H);
  localparam logic [9:0]       LAND_10   = 10'(FLOOR_Y - BLOCK_H);
  localparam logic [10:0]      MOVE_11   = 11'(MOVE_STEP);
  localparam logic [10:0]      START_X11 = 11'(START_X);
  localparam logic [9:0]       START_Y10 = 10'(START_Y);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAMES_PER_FALL - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FALLING = 2'd1,
    ST_LANDED  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [10:0]      x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_l_q, pend_l_d;
  logic             pend_r_q, pend_r_d;
  logic             left_prev_q, right_prev_q;
  logic             is_fixed_q, is_fixed_d;
  logic             active_q, active_d;
  logic             landed_q, landed_d;

  logic             rise_l, rise_r;
  logic             spawn_accept;
  logic             frame_move;
  logic             left_ok, right_ok;
  logic [11:0]      y_sum;
  logic [9:0]       y_fall;
  logic             land_hit;

  assign rise_l       = left_in & ~left_prev_q;
  assign rise_r       = right_in & ~right_prev_q;
  assign spawn_accept = spawn_in && (state_q != ST_FALLING);
  // A frame only moves the block while falling; spawn has priority over nf.
  assign frame_move   = nf_in && (state_q == ST_FALLING);

  assign left_ok  = (x_q >= MOVE_11);
  assign right_ok = ({1'b0, x_q} + MOVE_12 + BLKW_12) <= SCRW_12;

  // Gravity target, clamped to the floor; 12-bit sum cannot wrap.
  assign y_sum  = {2'b00, y_q} + FALL_12;
  assign y_fall = (y_sum > LAND_12) ? LAND_10 : y_sum[9:0];

  // Landing only happens on a gravity step of a falling frame.
  assign land_hit = frame_move && (cnt_q >= CNT_LAST) && (y_fall == LAND_10);

  // ---------------- state register ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (spawn_in) state_d = ST_FALLING;
      ST_FALLING: if (land_hit) state_d = ST_LANDED;
      ST_LANDED:  if (spawn_in) state_d = ST_FALLING;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------- output logic (registered flags) ----------------
  always_comb begin
    is_fixed_d = (state_d == ST_IDLE);
    active_d   = (state_d == ST_FALLING);
    landed_d   = land_hit;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    pend_l_d = pend_l_q | rise_l;
    pend_r_d = pend_r_q | rise_r;

    if (spawn_accept) begin
      x_d      = START_X11;
      y_d      = START_Y10;
      cnt_d    = '0;
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
    end else begin
      if (nf_in) begin
        // The frame consumes old requests; an edge in this cycle survives.
        pend_l_d = rise_l;
        pend_r_d = rise_r;
      end
      if (frame_move) begin
        if (pend_l_q && !pend_r_q && left_ok) begin
          x_d = x_q - MOVE_11;
        end else if (pend_r_q && !pend_l_q && right_ok) begin
          x_d = x_q + MOVE_11;
        end
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          y_d   = y_fall;
        end
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q          <= START_X11;
      y_q          <= START_Y10;
      cnt_q        <= '0;
      pend_l_q     <= 1'b0;
      pend_r_q     <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      is_fixed_q   <= 1'b1;
      active_q     <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      left_prev_q  <= left_in;
      right_prev_q <= right_in;
      is_fixed_q   <= is_fixed_d;
      active_q     <= active_d;
      landed_q     <= landed_d;
    end
  end

  assign x_out        = x_q;
  assign y_out        = y_q;
  assign is_fixed_out = is_fixed_q;
  assign active_out   = active_q;
  assign landed_out   = landed_q;

endmodule
